// File: rtl/morra_match_driver.sv
// Morra match driver: opens a match, plays two seeded LFSR players, tallies rounds.
// Optional round watchdog is compiled in with MORRA_DRIVER_TIMEOUT_EN.
module morra_match_driver #(
  parameter logic [7:0] SEED1 = 8'hA5,
  parameter logic [7:0] SEED2 = 8'h3C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [3:0] len,
  input  logic [1:0] ROUND,
  input  logic [1:0] GAME,
  output logic [1:0] P1,
  output logic [1:0] P2,
  output logic       START,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic [4:0] p1_wins,
  output logic [4:0] p2_wins,
  output logic [4:0] draws,
  output logic [4:0] nulls,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_SETTLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] S1 = (SEED1 == 8'h00) ? 8'h01 : SEED1;
  localparam logic [7:0] S2 = (SEED2 == 8'h00) ? 8'h01 : SEED2;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [1:0] pick(input logic [1:0] raw,
                                      input logic [1:0] fwd);
    logic [1:0] m;
    m = (raw == 2'b00) ? 2'b01 : raw;
    if (m == fwd) m = (m == 2'b11) ? 2'b01 : m + 2'b01;
    return m;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] x);
    return (x == 5'd31) ? x : x + 5'd1;
  endfunction

  state_t     state, nxt;
  logic [7:0] lfsr1, lfsr2;
  logic [7:0] lfsr1_n, lfsr2_n;
  logic [1:0] fwd1, fwd2;
  logic [1:0] fwd1_n, fwd2_n;
  logic [1:0] mv1, mv2;
  logic       accept;
  logic       in_wait;
  logic       tmo;

  assign accept  = (state == S_IDLE) && go;
  assign in_wait = (state == S_WAIT);

`ifdef MORRA_DRIVER_TIMEOUT_EN
  logic [4:0] rnd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_cnt <= 5'd0;
    end else if (accept) begin
      rnd_cnt <= 5'd0;
    end else if (in_wait && rnd_cnt != 5'd31) begin
      rnd_cnt <= rnd_cnt + 5'd1;
    end
  end

  // 24th WAIT is the last one allowed to end without a verdict
  assign tmo = in_wait && (GAME == 2'b00) && (rnd_cnt == 5'd23);
`else
  assign tmo = 1'b0;
`endif

  assign lfsr1_n = lfsr_step(lfsr1);
  assign lfsr2_n = lfsr_step(lfsr2);

  always_comb begin
    fwd1_n = fwd1;
    fwd2_n = fwd2;
    if (in_wait) begin
      unique case (ROUND)
        2'b01: begin fwd1_n = P1;    fwd2_n = 2'b00; end
        2'b10: begin fwd1_n = 2'b00; fwd2_n = P2;    end
        2'b11: begin fwd1_n = 2'b00; fwd2_n = 2'b00; end
        default: ;
      endcase
    end
  end

  // next moves must see the forbid set by the round that just ended
  assign mv1 = pick(lfsr1_n[1:0], fwd1_n);
  assign mv2 = pick(lfsr2_n[1:0], fwd2_n);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (go) nxt = S_OPEN;
      S_OPEN:   nxt = S_SETTLE;
      S_SETTLE: nxt = S_ISSUE;
      S_ISSUE:  nxt = S_WAIT;
      S_WAIT:   nxt = (GAME != 2'b00 || tmo) ? S_DONE : S_ISSUE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      START <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P1    <= 2'b00;
      P2    <= 2'b00;
      lfsr1 <= S1;
      lfsr2 <= S2;
    end else begin
      state <= nxt;
      START <= (nxt == S_OPEN);
      busy  <= (nxt != S_IDLE);
      done  <= (nxt == S_DONE);
      unique case (nxt)
        S_OPEN:  begin P1 <= len[3:2]; P2 <= len[1:0]; end
        S_ISSUE: begin P1 <= mv1;      P2 <= mv2;      end
        S_WAIT:  begin P1 <= P1;       P2 <= P2;       end
        default: begin P1 <= 2'b00;    P2 <= 2'b00;    end
      endcase
      if (nxt == S_ISSUE) begin
        lfsr1 <= lfsr1_n;
        lfsr2 <= lfsr2_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd1    <= 2'b00;
      fwd2    <= 2'b00;
      p1_wins <= 5'd0;
      p2_wins <= 5'd0;
      draws   <= 5'd0;
      nulls   <= 5'd0;
      err     <= 1'b0;
      result  <= 2'b00;
    end else if (accept) begin
      fwd1    <= 2'b00;
      fwd2    <= 2'b00;
      p1_wins <= 5'd0;
      p2_wins <= 5'd0;
      draws   <= 5'd0;
      nulls   <= 5'd0;
      err     <= 1'b0;
    end else begin
      fwd1 <= fwd1_n;
      fwd2 <= fwd2_n;
      if (in_wait) begin
        unique case (ROUND)
          2'b01: p1_wins <= sat_inc(p1_wins);
          2'b10: p2_wins <= sat_inc(p2_wins);
          2'b11: draws   <= sat_inc(draws);
          default: begin
            nulls <= sat_inc(nulls);
            err   <= 1'b1;
          end
        endcase
        if (GAME != 2'b00) result <= GAME;
      end
      if (tmo) begin
        err    <= 1'b1;
        result <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_morra_match_driver.sv
// Directed bench for morra_match_driver with a scripted game model and result scoreboard.
module tb_morra_match_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [3:0] len;
  logic [1:0] ROUND, GAME;
  logic [1:0] P1, P2;
  logic       START, busy, done, err;
  logic [1:0] result;
  logic [4:0] p1_wins, p2_wins, draws, nulls;

  morra_match_driver dut (
    .clk(clk), .rst(rst), .go(go), .len(len),
    .ROUND(ROUND), .GAME(GAME),
    .P1(P1), .P2(P2), .START(START), .busy(busy), .done(done),
    .result(result), .p1_wins(p1_wins), .p2_wins(p2_wins),
    .draws(draws), .nulls(nulls), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] result;
    logic [4:0] p1, p2, dr, nu;
    logic       err;
  } sb_t;

  sb_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0] rnd_tab [64];
  logic [1:0] game_tab [64];
  logic [7:0] m_l1, m_l2;
  logic [1:0] m_f1, m_f2;
  logic [1:0] m_res;
  logic [1:0] fm1, fm2;

  function automatic logic [7:0] step(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  function automatic logic [1:0] mv(input logic [7:0] s,
                                    input logic [1:0] f);
    logic [1:0] r;
    r = s[1:0];
    if (r == 2'b00) r = 2'b01;
    if (r == f) begin
      if (r == 2'b01) r = 2'b10;
      else if (r == 2'b10) r = 2'b11;
      else r = 2'b01;
    end
    return r;
  endfunction

  function automatic logic [4:0] sat(input logic [4:0] x);
    return (x == 5'd31) ? 5'd31 : x + 5'd1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [1:0] rdef, input int n,
                       input logic [1:0] glast);
    for (int i = 0; i < 64; i++) begin
      rnd_tab[i]  = rdef;
      game_tab[i] = 2'b00;
    end
    game_tab[n-1] = glast;
  endtask

  task automatic play(input logic [3:0] l, input int n);
    sb_t e, got;
    logic [1:0] e1, e2;
    e = '{result: m_res, p1: 5'd0, p2: 5'd0, dr: 5'd0, nu: 5'd0,
          err: 1'b0};
    m_f1 = 2'b00;
    m_f2 = 2'b00;
    go  = 1'b1;
    len = l;
    tick();
    go = 1'b0;
    chk("open_start", START, 1);
    chk("open_p1", P1, l[3:2]);
    chk("open_p2", P2, l[1:0]);
    chk("open_busy", busy, 1);
    tick();
    chk("settle_start", START, 0);
    chk("settle_p", {P1, P2}, 0);
    for (int r = 0; r < n; r++) begin
      tick();
      m_l1 = step(m_l1);
      m_l2 = step(m_l2);
      e1 = mv(m_l1, m_f1);
      e2 = mv(m_l2, m_f2);
      if (r == 0) begin
        fm1 = P1;
        fm2 = P2;
      end
      chk("move_p1", P1, e1);
      chk("move_p2", P2, e2);
      chk("forbid_p1", (P1 != m_f1) && (P1 != 2'b00), 1);
      ROUND = rnd_tab[r];
      GAME  = game_tab[r];
      tick();
      chk("hold", {P1, P2}, {e1, e2});
      chk("no_early_done", done, 0);
      case (rnd_tab[r])
        2'b01: begin e.p1 = sat(e.p1); m_f1 = e1; m_f2 = 2'b00; end
        2'b10: begin e.p2 = sat(e.p2); m_f2 = e2; m_f1 = 2'b00; end
        2'b11: begin e.dr = sat(e.dr); m_f1 = 2'b00; m_f2 = 2'b00; end
        default: begin e.nu = sat(e.nu); e.err = 1'b1; end
      endcase
      if (game_tab[r] != 2'b00) begin
        e.result = game_tab[r];
        break;
      end
`ifdef MORRA_DRIVER_TIMEOUT_EN
      if (r == 23) begin
        e.result = 2'b00;
        e.err = 1'b1;
        break;
      end
`endif
    end
    sb.push_back(e);
    tick();
    ROUND = 2'b00;
    GAME  = 2'b00;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_p", {P1, P2}, 0);
    got = sb.pop_front();
    m_res = got.result;
    chk("result", result, got.result);
    chk("p1_wins", p1_wins, got.p1);
    chk("p2_wins", p2_wins, got.p2);
    chk("draws", draws, got.dr);
    chk("nulls", nulls, got.nu);
    chk("err", err, got.err);
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_p"}, {P1, P2}, 0);
    chk({tag, "_start"}, START, 0);
    chk({tag, "_busy_done"}, {busy, done}, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_tallies"}, {p1_wins, p2_wins, draws, nulls, err}, 0);
  endtask

  initial begin
    rst   = 1'b1;
    go    = 1'b0;
    len   = 4'd0;
    ROUND = 2'b00;
    GAME  = 2'b00;
    m_l1  = 8'hA5;
    m_l2  = 8'h3C;
    m_res = 2'b00;
    repeat (2) tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // draws for 3 rounds, GAME=11 on round 4; first move pair from seeds
    setup(2'b11, 4, 2'b11);
    play(4'd0, 4);
    chk("seed_p1", fm1, 2'b10);
    chk("seed_p2", fm2, 2'b01);

    // len split across P1/P2; P1 keeps winning so forbid applies
    setup(2'b01, 3, 2'b01);
    play(4'b1011, 3);

    // one null round mid-match
    setup(2'b10, 4, 2'b10);
    rnd_tab[1] = 2'b00;
    play(4'd2, 4);

    // next go clears err
    setup(2'b11, 2, 2'b10);
    play(4'd1, 2);

    // null round together with final verdict
    setup(2'b01, 2, 2'b01);
    rnd_tab[1] = 2'b00;
    play(4'd3, 2);

`ifdef MORRA_DRIVER_TIMEOUT_EN
    setup(2'b01, 20, 2'b01);
    play(4'd5, 20);
`else
    // long P1 streak exercises rotation and tally saturation
    setup(2'b01, 35, 2'b01);
    play(4'd5, 35);
`endif

    // reset during WAIT of round 3
    setup(2'b11, 10, 2'b00);
    go = 1'b1;
    tick();
    go = 1'b0;
    ROUND = 2'b11;
    repeat (7) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    tick();
    rst = 1'b0;
    ROUND = 2'b00;
    repeat (3) tick();
    chk("no_restart", {START, busy}, 0);
    m_l1  = 8'hA5;
    m_l2  = 8'h3C;
    m_res = 2'b00;
    setup(2'b11, 2, 2'b01);
    play(4'd0, 2);
    chk("rst_seed_p1", fm1, 2'b10);
    chk("rst_seed_p2", fm2, 2'b01);

`ifdef MORRA_DRIVER_TIMEOUT_EN
    setup(2'b11, 40, 2'b00);
    play(4'd0, 40);
`else
    // no watchdog: match never ends while GAME stays 00
    go = 1'b1;
    tick();
    go = 1'b0;
    ROUND = 2'b11;
    repeat (99) tick();
    chk("hang_busy", busy, 1);
    chk("hang_done", done, 0);
    chk("hang_err", err, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ROUND = 2'b00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
